hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage core. It sits beside the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers and drives their stall (hold) and flush (bubble) controls. It resolves three hazard classes: load-use, taken branch/jump, and data-memory wait states with timeout. It also registers EX-stage forwarding selects as the ID/EXE register advances, and keeps saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive frozen cycles for one memory access (1..255).
- CNT_W, 16: width of the performance counters.

- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- rs1_id, rs2_id  input  4  source registers of the instruction in ID.
- uses_rs1_id, uses_rs2_id  input  1  the ID instruction actually reads rs1/rs2.
- rd_ex  input  4  destination register of the instruction in EX.
- regWrite_ex  input  1  EX instruction writes the register file.
- resultSrc_ex  input  2  EX result source; 2'b01 = load from memory.
- pcSrc_ex  input  1  taken branch/jump resolved in EX.
- rd_mem  input  4  destination register of the instruction in MEM.
- regWrite_mem  input  1  MEM instruction writes the register file.
- memAccess_mem  input  1  MEM instruction accesses data memory.
- mem_ready  input  1  data memory completes this cycle.
- stall_if, stall_id, stall_ex, stall_mem  output  1  hold PC / IF-ID / ID-EXE / EXE-MEM.
- flush_id, flush_ex  output  1  load a bubble into IF-ID / ID-EXE (control fields zeroed).
- fwdA_ex, fwdB_ex  output  2  registered operand select for EX: 00 register file, 10 from EXE/MEM, 01 from MEM/WB.
- busy  output  1  controller is in state MEM_WAIT.
- mem_err  output  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt  output  CNT_W  saturating performance counters.

## Operation
- FSM has two states, RUN and MEM_WAIT, plus a wait counter wait_cnt (8 bits).
- Register r0 never causes a hazard or a forward. A match means the destination equals the source, the destination is nonzero, and the corresponding uses_* input is 1.
- Conditions, evaluated in priority order each cycle:
  - freeze = memAccess_mem & ~mem_ready & (wait_cnt < MEM_TIMEOUT).
  - branch = pcSrc_ex & ~freeze.
  - loaduse = regWrite_ex & (resultSrc_ex==2'b01) & rd_ex matches rs1_id or rs2_id & ~freeze & ~branch.
- Outputs for each condition:
  - freeze: all four stall_* = 1; flush_* = 0.
  - branch: flush_id = 1 and flush_ex = 1; all stalls = 0, so the PC loads the branch target.
  - loaduse: stall_if = 1, stall_id = 1, flush_ex = 1; stall_ex = 0, stall_mem = 0.
  - None active: all stall/flush outputs = 0.
- FSM transitions:
  - RUN → MEM_WAIT when freeze; wait_cnt <= 1.
  - MEM_WAIT with freeze: stay; wait_cnt <= wait_cnt + 1.
  - MEM_WAIT with mem_ready = 1 → RUN; wait_cnt <= 0.
  - MEM_WAIT with wait_cnt == MEM_TIMEOUT and mem_ready = 0 → RUN; freeze is already 0 this cycle; wait_cnt <= 0; mem_err <= 1.
- mem_err is cleared only by reset.
- Forwarding registers, updated on each clk edge:
  - If flush_ex: fwdA_ex and fwdB_ex <= 00.
  - Else if stall_ex: hold.
  - Else, per operand: 10 if regWrite_ex and rd_ex matches; else 01 if regWrite_mem and rd_mem matches; else 00. The EX match wins over the MEM match.
- The register file is write-first; the WB stage needs no forward.
- stall_cnt increments on every cycle with stall_if = 1. flush_cnt increments on every branch cycle. Both saturate at all-ones.

## Timing
- stall_*, flush_*: combinational from the current-cycle inputs and state, valid in the same cycle. The pipeline registers act on the next clk edge.
- fwd*_ex, busy, mem_err, counters: registered, one-cycle latency.
- Reset (reset = 0 at an edge) sets: state RUN, wait_cnt 0, fwd 00, mem_err 0, counters 0.
- While reset is low, all stall/flush outputs are forced to 0.
- Reset asserted during MEM_WAIT returns the FSM to RUN on that edge with no error flagged.
- Load-use costs exactly one bubble. On the next cycle the load sits in MEM and the forward select becomes 01.
- A single memory access freezes the pipeline for at most MEM_TIMEOUT cycles.

## Test plan
- Load-use: EX holds a load with rd_ex=3, regWrite_ex=1, resultSrc_ex=01; ID has rs1_id=3 with uses_rs1_id=1. Required: stall_if=1, stall_id=1, flush_ex=1 for one cycle; next cycle fwdA_ex=01; stall_cnt=1.
- ALU forward: rd_ex=5 (regWrite_ex=1, not a load) and rd_mem=5 (regWrite_mem=1); ID has rs2_id=5. Required: no stall; after the edge fwdB_ex=10. Repeat with rd_ex=0: fwdB_ex=01.
- Branch priority: pcSrc_ex=1 in the same cycle as a load-use match. Required: flush_id=1, flush_ex=1, stall_if=0; flush_cnt=1; fwd registers = 00.
- Memory wait: memAccess_mem=1 with mem_ready=0 for 3 cycles, then 1. Required: all four stalls = 1 for 3 cycles; busy=1 from the 2nd cycle; back in RUN after mem_ready; mem_err=0.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0. Required: frozen 4 cycles; the 5th cycle is unfrozen; mem_err=1 after that edge and stays 1 until reset.
- Reset mid-wait: reset=0 during the 2nd MEM_WAIT cycle. Required: busy=0, counters=0, fwd=00 after the edge; stalls=0 while reset is low.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 16-bit five-stage core: load-use, branch flush,
// data-memory wait/timeout, registered EX forwarding selects and perf counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       rs1_id,
    input  logic [3:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [3:0]       rd_ex,
    input  logic             regWrite_ex,
    input  logic [1:0]       resultSrc_ex,
    input  logic             pcSrc_ex,
    input  logic [3:0]       rd_mem,
    input  logic             regWrite_mem,
    input  logic             memAccess_mem,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwdA_ex,
    output logic [1:0]       fwdB_ex,
    output logic             busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b10;
    localparam logic [1:0] FWD_MWB = 2'b01;
    localparam logic [1:0] SRC_LOAD = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [1:0]         fwd_a_q, fwd_a_d;
    logic [1:0]         fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic branch;
    logic loaduse;
    logic ex_m1, ex_m2, mem_m1, mem_m2;

    // r0 is hardwired zero, so it never creates a dependency
    function automatic logic reg_match(input logic [3:0] rd, input logic [3:0] src,
                                       input logic uses);
        return uses && (rd == src) && (rd != 4'd0);
    endfunction

    // Hazard detection, highest priority first
    always_comb begin
        ex_m1   = reg_match(rd_ex, rs1_id, uses_rs1_id);
        ex_m2   = reg_match(rd_ex, rs2_id, uses_rs2_id);
        mem_m1  = reg_match(rd_mem, rs1_id, uses_rs1_id);
        mem_m2  = reg_match(rd_mem, rs2_id, uses_rs2_id);
        freeze  = memAccess_mem && !mem_ready && (wait_cnt_q < TIMEOUT_CNT);
        branch  = pcSrc_ex && !freeze;
        loaduse = regWrite_ex && (resultSrc_ex == SRC_LOAD) && (ex_m1 || ex_m2)
                  && !freeze && !branch;
    end

    // Pipeline register controls; forced quiet while reset is held
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        if (reset) begin
            if (freeze) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
            end else if (branch) begin
                flush_id  = 1'b1;
                flush_ex  = 1'b1;
            end else if (loaduse) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_ex  = 1'b1;
            end
        end
    end

    // Memory wait FSM; an expired wait releases the pipeline and latches the error
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (freeze) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (!mem_ready && (wait_cnt_q == TIMEOUT_CNT)) begin
                        mem_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Forward selects follow the instruction entering EX; EXE/MEM beats MEM/WB
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (flush_ex) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end else if (!stall_ex) begin
            if (regWrite_ex && ex_m1)        fwd_a_d = FWD_EXM;
            else if (regWrite_mem && mem_m1) fwd_a_d = FWD_MWB;
            else                             fwd_a_d = FWD_RF;
            if (regWrite_ex && ex_m2)        fwd_b_d = FWD_EXM;
            else if (regWrite_mem && mem_m2) fwd_b_d = FWD_MWB;
            else                             fwd_b_d = FWD_RF;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwdA_ex   = fwd_a_q;
    assign fwdB_ex   = fwd_b_q;
    assign busy      = (state_q == MEM_WAIT);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
